// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative RV32M multiply/divide unit (radix-2 shift-add multiply, restoring divide).
// Build macro MULDIV_FAST_SPECIAL_EN: div-by-zero and signed overflow complete straight from PREP.
module muldiv_sequencer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Start,
  input  logic                  Flush,
  input  logic [2:0]            Funct3,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  output logic                  Busy,
  output logic                  Done,
  output logic [DATA_WIDTH-1:0] Result
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH) + 1;
  localparam logic [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t          r_state;
  logic [2:0]      r_op;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_mcand;
  logic [2*W-1:0]  r_acc;
  logic [CW-1:0]   r_cnt;
  logic            r_neg;
  logic            r_rem_neg;
  logic            r_div0;
  logic            r_ovf;
  logic            r_busy;
  logic            r_done;
  logic [W-1:0]    r_result;

  // Operand decode, evaluated in PREP from the latched request
  logic         w_is_div;
  logic         w_sign_a;
  logic         w_sign_b;
  logic         w_a_neg;
  logic         w_b_neg;
  logic         w_div0;
  logic         w_ovf;
  logic [W-1:0] w_abs_a;
  logic [W-1:0] w_abs_b;

  assign w_is_div = r_op[2];
  assign w_sign_a = (r_op == 3'b001) || (r_op == 3'b010) || (r_op == 3'b100) || (r_op == 3'b110);
  assign w_sign_b = (r_op == 3'b001) || (r_op == 3'b100) || (r_op == 3'b110);
  assign w_a_neg  = w_sign_a & r_a[W-1];
  assign w_b_neg  = w_sign_b & r_b[W-1];
  assign w_abs_a  = w_a_neg ? -r_a : r_a;
  assign w_abs_b  = w_b_neg ? -r_b : r_b;
  assign w_div0   = w_is_div && (r_b == '0);
  assign w_ovf    = w_is_div && !r_op[0] && (r_a == MIN) && (r_b == '1);

  // Multiply step: accumulator high half collects partial sums, low half holds the multiplier
  logic [W:0]     w_mul_sum;
  logic [2*W-1:0] w_mul_step;

  assign w_mul_sum  = {1'b0, r_acc[2*W-1:W]} + {1'b0, r_mcand};
  assign w_mul_step = r_acc[0] ? {w_mul_sum, r_acc[W-1:1]} : {1'b0, r_acc[2*W-1:1]};

  // Divide step: accumulator is {remainder, quotient}; the shifted remainder needs one extra bit
  logic [W:0]     w_rem_sh;
  logic           w_fits;
  logic [W-1:0]   w_diff;
  logic [2*W-1:0] w_div_step;

  assign w_rem_sh   = {r_acc[2*W-1:W], r_acc[W-1]};
  assign w_fits     = w_rem_sh >= {1'b0, r_mcand};
  assign w_diff     = w_rem_sh[W-1:0] - r_mcand;
  assign w_div_step = w_fits ? {w_diff, r_acc[W-2:0], 1'b1}
                             : {w_rem_sh[W-1:0], r_acc[W-2:0], 1'b0};

  // Sign fix-up and word selection
  logic [2*W-1:0] w_prod;
  logic [W-1:0]   w_quot;
  logic [W-1:0]   w_remv;
  logic [W-1:0]   w_fix_result;

  assign w_prod = r_neg ? -r_acc : r_acc;
  assign w_quot = r_neg ? -r_acc[W-1:0] : r_acc[W-1:0];
  assign w_remv = r_rem_neg ? -r_acc[2*W-1:W] : r_acc[2*W-1:W];

  always_comb begin
    w_fix_result = w_remv;
    case (r_op)
      3'b000:                 w_fix_result = w_prod[W-1:0];
      3'b001, 3'b010, 3'b011: w_fix_result = w_prod[2*W-1:W];
      3'b100, 3'b101:         w_fix_result = w_quot;
      default:                w_fix_result = w_remv;
    endcase
  end

  function automatic logic [W-1:0] special_word(input logic div0, input logic rem_sel,
                                                input logic [W-1:0] dividend);
    if (div0) return rem_sel ? dividend : '1;
    return rem_sel ? '0 : MIN;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_op      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_mcand   <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_neg     <= 1'b0;
      r_rem_neg <= 1'b0;
      r_div0    <= 1'b0;
      r_ovf     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_result  <= '0;
    end else if (Flush) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (Start) begin
            r_op    <= Funct3;
            r_a     <= SrcA;
            r_b     <= SrcB;
            r_state <= S_PREP;
            r_busy  <= 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_PREP: begin
          r_mcand   <= w_is_div ? w_abs_b : w_abs_a;
          r_acc     <= {{W{1'b0}}, (w_is_div ? w_abs_a : w_abs_b)};
          r_cnt     <= '0;
          r_neg     <= w_a_neg ^ w_b_neg;
          r_rem_neg <= w_a_neg;
          r_div0    <= w_div0;
          r_ovf     <= w_ovf;
          r_state   <= S_CALC;
`ifdef MULDIV_FAST_SPECIAL_EN
          if (w_div0 || w_ovf) begin
            r_result <= special_word(w_div0, r_op[1], r_a);
            r_state  <= S_DONE;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
          end
`else
`endif
        end
        S_CALC: begin
          r_acc <= w_is_div ? w_div_step : w_mul_step;
          if (r_cnt == CW'(W - 1)) begin
            r_state <= S_FIX;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_FIX: begin
          r_result <= (r_div0 || r_ovf) ? special_word(r_div0, r_op[1], r_a) : w_fix_result;
          r_state  <= S_DONE;
          r_busy   <= 1'b0;
          r_done   <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign Busy   = r_busy;
  assign Done   = r_done;
  assign Result = r_result;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: scoreboard of expected results and completion cycles.
module tb_muldiv_sequencer;
  localparam int LAT = 35;
`ifdef MULDIV_FAST_SPECIAL_EN
  localparam int SPECIAL_LAT = 2;
`else
  localparam int SPECIAL_LAT = 35;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic        Flush;
  logic [2:0]  Funct3;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        Busy;
  logic        Done;
  logic [31:0] Result;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cnt = 0;
  int tracked_cnt = 0;
  logic [31:0] last_exp = '0;

  string       q_tag[$];
  logic [31:0] q_exp[$];
  int          q_cyc[$];

  muldiv_sequencer #(.DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .Start(Start), .Flush(Flush), .Funct3(Funct3),
    .SrcA(SrcA), .SrcB(SrcB), .Busy(Busy), .Done(Done), .Result(Result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    longint sa, sb;
    bit ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = '0;
    case (f3)
      3'd0: return a * b;
      3'd1: p = sa * sb;
      3'd2: p = sa * longint'({32'b0, b});
      3'd3: p = {32'b0, a} * {32'b0, b};
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
      default: return (b == 0) ? a : a % b;
    endcase
    return p[63:32];
  endfunction

  function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    return f3[2] && ((b == 0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Called just after a falling edge; that cycle is cycle 0 of the request.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input string tag, input bit track);
    Start = 1'b1; Funct3 = f3; SrcA = a; SrcB = b;
    if (track) begin
      q_tag.push_back(tag);
      q_exp.push_back(exp);
      q_cyc.push_back(cyc + (is_special(f3, a, b) ? SPECIAL_LAT : LAT));
      tracked_cnt++;
    end
    @(negedge clk);
    Start = 1'b0; Funct3 = 3'($urandom); SrcA = $urandom; SrcB = $urandom;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!Done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!Done) chk("wait_done_timeout", {31'b0, Done}, 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (q_exp.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", q_exp.size(), 32'd0);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (Done) begin
      done_cnt++;
      chk("busy_with_done", {31'b0, Busy}, 32'd0);
      chk("ops_pending_at_done", {31'b0, (q_exp.size() > 0)}, 32'd1);
      if (q_exp.size() > 0) begin
        string t;
        logic [31:0] e;
        int c;
        t = q_tag.pop_front();
        e = q_exp.pop_front();
        c = q_cyc.pop_front();
        chk(t, Result, e);
        chk({t, "_cycle"}, 32'(cyc), 32'(c));
        last_exp = e;
        $display("op %-8s result=0x%08h expected=0x%08h done_cycle=%0d", t, Result, e, cyc);
      end
    end
  end

  initial begin
    logic [2:0]  f3;
    logic [31:0] a, b;
    int          saved;
    reset = 1'b1; Start = 1'b0; Flush = 1'b0; Funct3 = '0; SrcA = '0; SrcB = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", {31'b0, Busy}, 32'd0);
    chk("reset_done", {31'b0, Done}, 32'd0);
    chk("reset_result", Result, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // MUL with Busy/Done profile across the whole op
    issue(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul", 1'b1);
    for (int k = 1; k <= 35; k++) begin
      chk($sformatf("busy_c%0d", k), {31'b0, Busy}, {31'b0, (k <= 34)});
      chk($sformatf("done_c%0d", k), {31'b0, Done}, {31'b0, (k == 35)});
      if (k < 35) @(negedge clk);
    end
    drain();

    issue(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh", 1'b1);   drain();
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu", 1'b1);  drain();
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu", 1'b1); drain();

    // Back-to-back issue in the DONE cycle
    issue(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "div", 1'b1);  wait_done();
    issue(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "rem", 1'b1);  wait_done();
    issue(3'd5, 32'd100, 32'd7, 32'd14, "divu", 1'b1);              wait_done();
    issue(3'd7, 32'd100, 32'd7, 32'd2, "remu", 1'b1);               drain();

    // Special cases
    issue(3'd4, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, "div_z", 1'b1);  drain();
    issue(3'd5, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, "divu_z", 1'b1); drain();
    issue(3'd6, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, "rem_z", 1'b1);  drain();
    issue(3'd7, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, "remu_z", 1'b1); drain();
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ov", 1'b1); wait_done();
    issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, "rem_ov", 1'b1); drain();

    // Start while busy is ignored
    issue(3'd0, 32'd9, 32'd11, 32'd99, "mul_ign", 1'b1);
    repeat (9) @(negedge clk);
    Start = 1'b1; Funct3 = 3'd5; SrcA = 32'd50; SrcB = 32'd3;
    @(negedge clk);
    Start = 1'b0;
    drain();
    repeat (40) @(negedge clk);
    chk("one_done_only", 32'(done_cnt), 32'(tracked_cnt));

    // Flush mid-op
    saved = done_cnt;
    issue(3'd0, 32'd123, 32'd456, 32'd0, "flushed", 1'b0);
    repeat (11) @(negedge clk);
    Flush = 1'b1;
    @(negedge clk);
    Flush = 1'b0;
    chk("flush_busy", {31'b0, Busy}, 32'd0);
    chk("flush_done", {31'b0, Done}, 32'd0);
    chk("flush_result", Result, last_exp);
    repeat (40) @(negedge clk);
    chk("flush_no_done", 32'(done_cnt), 32'(saved));

    // Flush beats Start
    Start = 1'b1; Flush = 1'b1; Funct3 = 3'd0; SrcA = 32'd3; SrcB = 32'd3;
    @(negedge clk);
    Start = 1'b0; Flush = 1'b0;
    chk("flush_start_busy", {31'b0, Busy}, 32'd0);
    repeat (40) @(negedge clk);
    chk("flush_start_no_done", 32'(done_cnt), 32'(saved));

    // Reset mid-CALC
    issue(3'd0, 32'd77, 32'd88, 32'd0, "reset_lost", 1'b0);
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_busy", {31'b0, Busy}, 32'd0);
    chk("midrst_done", {31'b0, Done}, 32'd0);
    chk("midrst_result", Result, 32'd0);
    issue(3'd0, 32'd3, 32'd5, 32'd15, "mul_3x5", 1'b1);
    drain();

    // Random back-to-back ops against the reference model
    for (int i = 0; i < 16; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if (i % 3 == 0) b = b >> 20;
      issue(f3, a, b, model(f3, a, b), $sformatf("rnd%0d_f%0d", i, f3), 1'b1);
      wait_done();
    end
    drain();

    chk("done_count", 32'(done_cnt), 32'(tracked_cnt));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
